// File: rtl/load_data.sv
// load_data: reads one 64-byte line from the system bus as 8 response beats.
// Ports: clk/reset, enable+addr start, arbiter req/grant, bus req/resp, ready+data.
module load_data #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [63:0]                 addr,
    input  logic                        abtr_grant,
    output logic                        abtr_reqcyc,
    output logic                        bus_busy,
    output logic                        main_bus_reqcyc,
    input  logic                        main_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0]   main_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]    main_bus_reqtag,
    input  logic                        main_bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]   main_bus_resp,
    output logic                        main_bus_respack,
    output logic                        ready,
    output logic [8*BUS_DATA_WIDTH-1:0] data
);

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic [3:0] SYSBUS_MEMORY = 4'h1;
    localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG =
        BUS_TAG_WIDTH'({SYSBUS_READ, SYSBUS_MEMORY, 8'h00});

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ADDR,
        S_RESP,
        S_READY
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [57:0] line_q;
    logic [2:0]  cnt_q;
    logic [8*BUS_DATA_WIDTH-1:0] data_q;

    logic start;
    logic beat;

    // Only the line base is kept; the byte offset inside the line is dropped.
    logic unused_offset;
    assign unused_offset = ^addr[5:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        abtr_reqcyc      = 1'b0;
        bus_busy         = 1'b0;
        main_bus_reqcyc  = 1'b0;
        main_bus_req     = '0;
        main_bus_reqtag  = '0;
        main_bus_respack = 1'b0;
        ready            = 1'b0;
        start            = 1'b0;
        beat             = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    start   = 1'b1;
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                abtr_reqcyc = 1'b1;
                if (abtr_grant) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                abtr_reqcyc     = 1'b1;
                bus_busy        = 1'b1;
                main_bus_reqcyc = 1'b1;
                main_bus_req    = {line_q, 6'b0};
                main_bus_reqtag = READ_TAG;
                if (main_bus_reqack) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                abtr_reqcyc      = 1'b1;
                bus_busy         = 1'b1;
                main_bus_respack = main_bus_respcyc;
                beat             = main_bus_respcyc;
                // Leave on the eighth accepted beat so the counter never wraps in use.
                if (main_bus_respcyc && cnt_q == 3'd7) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                ready = 1'b1;
                if (enable) begin
                    start   = 1'b1;
                    state_d = S_ARB;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            line_q <= addr[63:6];
            cnt_q  <= '0;
        end else if (beat) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else if (beat) begin
            for (int i = 0; i < 8; i++) begin
                if (cnt_q == 3'(i)) begin
                    data_q[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= main_bus_resp;
                end
            end
        end
    end

    assign data = data_q;

endmodule

// File: tb/tb_load_data.sv
// tb_load_data: directed scenarios for load_data with a line-level reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_load_data;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [63:0]  addr;
    logic         abtr_grant;
    logic         abtr_reqcyc;
    logic         bus_busy;
    logic         main_bus_reqcyc;
    logic         main_bus_reqack;
    logic [63:0]  main_bus_req;
    logic [12:0]  main_bus_reqtag;
    logic         main_bus_respcyc;
    logic [63:0]  main_bus_resp;
    logic         main_bus_respack;
    logic         ready;
    logic [511:0] data;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    load_data dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .addr             (addr),
        .abtr_grant       (abtr_grant),
        .abtr_reqcyc      (abtr_reqcyc),
        .bus_busy         (bus_busy),
        .main_bus_reqcyc  (main_bus_reqcyc),
        .main_bus_reqack  (main_bus_reqack),
        .main_bus_req     (main_bus_req),
        .main_bus_reqtag  (main_bus_reqtag),
        .main_bus_respcyc (main_bus_respcyc),
        .main_bus_resp    (main_bus_resp),
        .main_bus_respack (main_bus_respack),
        .ready            (ready),
        .data             (data)
    );

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line-level model: phase 0 idle, 1 waiting grant, 2 request, 3 beats, 4 line ready.
    int          m_ph;
    int          m_got;
    logic [63:0] m_base;
    logic [63:0] m_lane [8];
    logic [511:0] exp_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ph   <= 0;
            m_got  <= 0;
            m_base <= '0;
            for (int i = 0; i < 8; i++) m_lane[i] <= '0;
        end else begin
            if ((m_ph == 0 || m_ph == 4) && enable) begin
                m_ph   <= 1;
                m_got  <= 0;
                m_base <= addr & ~64'h3f;
            end else if (m_ph == 1 && abtr_grant) begin
                m_ph <= 2;
            end else if (m_ph == 2 && main_bus_reqack) begin
                m_ph <= 3;
            end else if (m_ph == 3 && main_bus_respcyc) begin
                m_lane[m_got] <= main_bus_resp;
                m_got <= m_got + 1;
                if (m_got == 7) m_ph <= 4;
            end
        end
    end

    always_comb begin
        exp_data = '0;
        for (int i = 0; i < 8; i++) exp_data[i*64 +: 64] = m_lane[i];
    end

    always @(negedge clk) begin
        chk("abtr_reqcyc", abtr_reqcyc, m_ph inside {1, 2, 3});
        chk("bus_busy", bus_busy, m_ph inside {2, 3});
        chk("reqcyc", main_bus_reqcyc, m_ph == 2);
        chk("req", main_bus_req, (m_ph == 2) ? m_base : 64'h0);
        chk("reqtag", main_bus_reqtag, (m_ph == 2) ? 13'h1100 : 13'h0);
        chk("respack", main_bus_respack, m_ph == 3 && main_bus_respcyc);
        chk("ready", ready, m_ph == 4);
        chk("data", data, exp_data);
    end

    logic [63:0]  seen_req;
    logic [12:0]  seen_tag;
    logic [63:0]  last_req;
    logic [12:0]  last_tag;
    logic         pre_ready;
    logic [511:0] bts;
    int           e;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_line(input logic [63:0] a);
        enable = 1'b1;
        addr   = a;
        tick();
        enable = 1'b0;
        addr   = 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    // Drives grant/reqack with the given stalls, then the respcyc pattern (LSB first).
    task automatic line_body(input int g, input int a, input logic [15:0] pat,
                             input int plen, input int en_at,
                             input logic [511:0] beats, output int edges);
        int b;
        b     = 0;
        edges = 1;
        for (int i = 0; i < g; i++) begin
            tick();
            edges++;
        end
        abtr_grant = 1'b1;
        tick();
        edges++;
        abtr_grant = 1'b0;
        seen_req = main_bus_req;
        seen_tag = main_bus_reqtag;
        for (int i = 0; i < a; i++) begin
            tick();
            edges++;
        end
        last_req = main_bus_req;
        last_tag = main_bus_reqtag;
        main_bus_reqack = 1'b1;
        tick();
        edges++;
        main_bus_reqack = 1'b0;
        for (int i = 0; i < plen; i++) begin
            main_bus_respcyc = pat[i];
            main_bus_resp = pat[i] ? beats[b*64 +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
            if (pat[i]) b++;
            enable = (i == en_at);
            if (i == en_at) addr = 64'h7777_7777_7777_7777;
            pre_ready = ready;
            tick();
            edges++;
        end
        enable           = 1'b0;
        main_bus_respcyc = 1'b0;
        main_bus_resp    = '0;
    endtask

    initial begin
        reset            = 1'b0;
        enable           = 1'b0;
        addr             = '0;
        abtr_grant       = 1'b0;
        main_bus_reqack  = 1'b0;
        main_bus_respcyc = 1'b0;
        main_bus_resp    = '0;
        repeat (3) tick();
        chk("rst_data", data, 512'h0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_abtr", abtr_reqcyc, 1'b0);
        chk("rst_busy", bus_busy, 1'b0);
        chk("rst_reqcyc", main_bus_reqcyc, 1'b0);
        chk("rst_req", main_bus_req, 64'h0);
        chk("rst_tag", main_bus_reqtag, 13'h0);
        chk("rst_respack", main_bus_respack, 1'b0);
        reset = 1'b1;
        tick();

        // Nominal line
        for (int i = 0; i < 8; i++) bts[i*64 +: 64] = 64'(i + 1);
        start_line(64'h1234_5678_9ABC_DEFF);
        line_body(0, 0, 16'h00FF, 8, -1, bts, e);
        chk("nom_req", seen_req, 64'h1234_5678_9ABC_DEC0);
        chk("nom_tag", seen_tag, 13'h1100);
        chk("nom_latency", e, 11);
        chk("nom_pre_ready", pre_ready, 1'b0);
        chk("nom_ready", ready, 1'b1);
        chk("nom_lane0", data[63:0], 64'h1);
        chk("nom_lane7", data[511:448], 64'h8);

        // Grant and reqack stalls
        for (int i = 0; i < 8; i++) bts[i*64 +: 64] = 64'h5100 + 64'(i);
        start_line(64'h0000_0000_0000_107F);
        line_body(3, 2, 16'h00FF, 8, -1, bts, e);
        chk("stall_req_first", seen_req, 64'h1040);
        chk("stall_req_last", last_req, 64'h1040);
        chk("stall_tag_last", last_tag, 13'h1100);
        chk("stall_latency", e, 16);
        chk("stall_ready", ready, 1'b1);

        // Gapped responses 1,0,1,1,0,0,1,1,1,1,1
        for (int i = 0; i < 8; i++) bts[i*64 +: 64] = {56'hA0A0_A0A0_A0A0_A0, 8'(i)};
        start_line(64'hFFFF_FFFF_FFFF_FFC0);
        line_body(0, 0, 16'h07CD, 11, -1, bts, e);
        chk("gap_latency", e, 14);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("gap_lane%0d", i), data[i*64 +: 64],
                {56'hA0A0_A0A0_A0A0_A0, 8'(i)});
        end

        // Back-to-back: enable while ready
        for (int i = 0; i < 8; i++) bts[i*64 +: 64] = 64'hB000_0000_0000_0000 + 64'(i);
        start_line(64'h0BAD_CAFE_0000_0080);
        chk("b2b_ready_drop", ready, 1'b0);
        line_body(0, 0, 16'h00FF, 8, -1, bts, e);
        chk("b2b_data", data, {64'hB000_0000_0000_0007, 64'hB000_0000_0000_0006,
                               64'hB000_0000_0000_0005, 64'hB000_0000_0000_0004,
                               64'hB000_0000_0000_0003, 64'hB000_0000_0000_0002,
                               64'hB000_0000_0000_0001, 64'hB000_0000_0000_0000});
        chk("b2b_ready", ready, 1'b1);

        // Reset in the middle of the beats
        for (int i = 0; i < 8; i++) bts[i*64 +: 64] = 64'hC000_0000_0000_0000 + 64'(i);
        start_line(64'h0000_0000_0000_3000);
        line_body(0, 0, 16'h000F, 4, -1, bts, e);
        chk("mid_busy", bus_busy, 1'b1);
        main_bus_respcyc = 1'b1;
        main_bus_resp    = 64'hFFFF_FFFF_FFFF_FFFF;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_data", data, 512'h0);
        chk("arst_abtr", abtr_reqcyc, 1'b0);
        chk("arst_busy", bus_busy, 1'b0);
        chk("arst_respack", main_bus_respack, 1'b0);
        chk("arst_reqcyc", main_bus_reqcyc, 1'b0);
        chk("arst_ready", ready, 1'b0);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("idle_respack", main_bus_respack, 1'b0);
        chk("idle_data", data, 512'h0);
        main_bus_respcyc = 1'b0;
        main_bus_resp    = '0;

        // Restart after reset, enable pulsed during beats
        for (int i = 0; i < 8; i++) bts[i*64 +: 64] = 64'hD000_0000_0000_0000 + 64'(i);
        start_line(64'h0000_0000_0000_2000);
        line_body(0, 0, 16'h00FF, 8, 3, bts, e);
        chk("restart_latency", e, 11);
        chk("restart_ready", ready, 1'b1);
        chk("restart_lane0", data[63:0], 64'hD000_0000_0000_0000);
        chk("restart_lane7", data[511:448], 64'hD000_0000_0000_0007);

        // Stray response traffic while ready
        main_bus_respcyc = 1'b1;
        main_bus_resp    = 64'h5555_5555_5555_5555;
        tick();
        chk("stray_respack", main_bus_respack, 1'b0);
        tick();
        chk("stray_lane0", data[63:0], 64'hD000_0000_0000_0000);
        chk("stray_ready", ready, 1'b1);
        main_bus_respcyc = 1'b0;
        main_bus_resp    = '0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/load_data.md
LOAD_DATA -- requirements
Module: load_data

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, system bus beat width.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, bus tag width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset (port names: clk, reset).
REQ-004 Ports, in order (name  direction  width  meaning):
- clk  in  1  clock.
- reset  in  1  async active-low reset.
- enable  in  1  start a line read.
- addr  in  64  byte address of the line to read.
- abtr_grant  in  1  arbiter grant.
- abtr_reqcyc  out  1  arbiter request.
- bus_busy  out  1  block owns the bus.
- main_bus_reqcyc  out  1  request beat valid.
- main_bus_reqack  in  1  request beat accepted.
- main_bus_req  out  64  request payload.
- main_bus_reqtag  out  BUS_TAG_WIDTH  request tag.
- main_bus_respcyc  in  1  response beat valid.
- main_bus_resp  in  64  response payload.
- main_bus_respack  out  1  response beat accepted.
- ready  out  1  line in data is valid.
- data  out  512  assembled 64-byte line.

Function
REQ-005 SHALL implement states IDLE, ARB, ADDR, RESP and READY.
REQ-006 IDLE: on enable=1, go to ARB and latch addr; otherwise stay in IDLE.
REQ-007 ARB: drive abtr_reqcyc=1; go to ADDR on abtr_grant=1, else stay in ARB.
REQ-008 ADDR outputs:
- main_bus_reqcyc=1
- main_bus_req={latched addr[63:6], 6'b0}
- main_bus_reqtag=13'h1100 (SYSBUS_READ=1 in bit 12, SYSBUS_MEMORY=4'h1 in bits 11:8, bits 7:0 zero)
REQ-009 ADDR: go to RESP on main_bus_reqack=1; otherwise hold all ADDR outputs unchanged.
REQ-010 RESP: drive main_bus_reqcyc=0 and main_bus_respack=main_bus_respcyc (same cycle, combinational).
REQ-011 RESP: on each cycle with respcyc=1, write main_bus_resp into data[64k+63:64k], where k is the 3-bit beat counter, then increment k.
REQ-012 RESP: a cycle with respcyc=0 SHALL change neither k nor data (gaps tolerated indefinitely).
REQ-013 The beat counter SHALL be cleared on entry to ARB; after the beat with k=7 is accepted, go to READY (exactly 8 beats, no wrap into a 9th).
REQ-014 abtr_reqcyc SHALL be 1 in ARB, ADDR and RESP, and 0 in IDLE and READY.
REQ-015 bus_busy SHALL be 1 in ADDR and RESP only.
REQ-016 READY: drive ready=1 and hold data stable.
REQ-017 READY: on enable=1, latch the new addr and go to ARB; ready drops to 0 the next cycle.
REQ-018 enable SHALL be ignored in ARB, ADDR and RESP, and addr is sampled only when enable is accepted.
REQ-019 Latency from enable accepted to ready is 3 cycles plus grant wait, reqack wait and 8 beat cycles; minimum 11 cycles with immediate grant, reqack and back-to-back beats.
REQ-020 main_bus_req and main_bus_reqtag SHALL be 0 outside ADDR; main_bus_respack SHALL be 0 outside RESP.
REQ-021 respcyc=1 outside RESP SHALL be ignored: no respack, no data change.

Reset
REQ-022 reset=0 SHALL immediately (asynchronously) force IDLE; outputs and internal registers take these values:
- data=0, counter=0, latched address=0
- ready, abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack = 0
- main_bus_req=0, main_bus_reqtag=0
REQ-023 Reset asserted mid-transfer SHALL abandon the transfer with no further bus handshakes; after release, the block waits for a fresh enable.

Verification
REQ-024 Bench SHALL cover the following directed scenarios:
- Nominal: addr=64'h1234_5678_9ABC_DEFF, immediate grant and reqack, beats 1..8 back-to-back -> req=64'h1234_5678_9ABC_DEC0, tag=13'h1100, ready at cycle 11, data[63:0]=1, data[511:448]=8.
- Stalls: grant delayed 3 cycles, reqack delayed 2 cycles -> reqcyc/req/tag held constant in ADDR; ready at cycle 16.
- Gapped responses: respcyc pattern 1,0,1,1,0,0,1,1,1,1,1 with beats A0..A7 -> respack mirrors respcyc in RESP; data lanes 0..7 = A0..A7.
- Back-to-back: enable held in READY with new addr -> ready low next cycle; second line fully replaces data; ready reasserts.
- Reset mid-RESP after 4 beats -> all outputs 0 immediately; later enable restarts cleanly from beat 0.
- Stray traffic: respcyc=1 in IDLE and in READY, plus enable pulsed in RESP -> no respack, data unchanged, no restart.
